// File: rtl/puncture_sched_pkg.sv
// Shared types for the puncture rate scheduler: FSM state encoding and the rate table entry.
// Entry field widths are fixed here; the scheduler's MAX_LEN must match MaxLen.
package puncture_sched_pkg;

  localparam int unsigned MaxLen = 8;
  localparam int unsigned LenW   = $clog2(MaxLen);

  typedef enum logic [1:0] {
    StIdle,
    StCfg,
    StPass
  } state_e;

  typedef struct packed {
    logic [LenW-1:0]   len;
    logic [MaxLen-1:0] vec;
  } rate_entry_t;

endpackage

// File: rtl/puncture_rate_table.sv
// Rate table: NUM_RATES register entries loaded with defaults on reset, one write port,
// one asynchronous read port, and per-entry dirty bits set by writes and cleared when applied.
module puncture_rate_table
  import puncture_sched_pkg::*;
#(
  parameter int unsigned NUM_RATES     = 4,
  parameter int unsigned RW            = $clog2(NUM_RATES),
  parameter rate_entry_t DEFAULT_ENTRY = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we_i,
  input  logic [RW-1:0]        waddr_i,
  input  rate_entry_t          wdata_i,
  input  logic [RW-1:0]        raddr_i,
  input  logic                 apply_i,
  output rate_entry_t          rdata_o,
  output logic [NUM_RATES-1:0] dirty_o
);

  rate_entry_t          tbl_q [NUM_RATES];
  logic [NUM_RATES-1:0] dirty_q, dirty_d;

  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(NUM_RATES); i++) begin
      if (reset) begin
        tbl_q[i] <= DEFAULT_ENTRY;
      end else if (we_i && waddr_i == RW'(i)) begin
        tbl_q[i] <= wdata_i;
      end
    end
  end

  always_comb begin
    rdata_o = tbl_q[0];
    for (int i = 0; i < int'(NUM_RATES); i++) begin
      if (raddr_i == RW'(i)) rdata_o = tbl_q[i];
    end
  end

  // A write landing in the same cycle the entry is applied wins: the new value is still pending.
  always_comb begin
    dirty_d = dirty_q;
    for (int i = 0; i < int'(NUM_RATES); i++) begin
      if (apply_i && raddr_i == RW'(i)) dirty_d[i] = 1'b0;
      if (we_i && waddr_i == RW'(i))    dirty_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) dirty_q <= '0;
    else       dirty_q <= dirty_d;
  end

  assign dirty_o = dirty_q;

endmodule

// File: rtl/puncture_rate_sched.sv
// Per-packet puncturing rate scheduler: takes one rate beat per packet, issues a one-cycle
// puncturer config when needed, then forwards the packet. PUNCTURE_SCHED_STATS_EN adds counters.
module puncture_rate_sched
  import puncture_sched_pkg::*;
#(
  parameter int unsigned WIDTH                   = 32,
  parameter int unsigned MAX_LEN                 = 8,
  parameter int unsigned NUM_RATES               = 4,
  parameter int unsigned DEFAULT_VECTOR_LEN      = 8,
  parameter logic [MAX_LEN-1:0] DEFAULT_PUNCTURE_VECTOR = 8'hFF,
  localparam int unsigned LW = $clog2(MAX_LEN),
  localparam int unsigned RW = $clog2(NUM_RATES),
  localparam int unsigned SW = RW + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear_i,
  input  logic               tbl_we_i,
  input  logic [RW-1:0]      tbl_addr_i,
  input  logic [LW-1:0]      tbl_len_i,
  input  logic [MAX_LEN-1:0] tbl_vec_i,
  input  logic [SW-1:0]      rate_tdata_i,
  input  logic               rate_tvalid_i,
  output logic               rate_tready_o,
  input  logic [WIDTH-1:0]   i_tdata_i,
  input  logic               i_tlast_i,
  input  logic               i_tvalid_i,
  output logic               i_tready_o,
  output logic [WIDTH-1:0]   o_tdata_o,
  output logic               o_tlast_o,
  output logic               o_tvalid_o,
  input  logic               o_tready_i,
  output logic [LW-1:0]      vector_len_tdata_o,
  output logic               vector_len_tvalid_o,
  output logic [MAX_LEN-1:0] puncture_vector_tdata_o,
  output logic               puncture_vector_tvalid_o
`ifdef PUNCTURE_SCHED_STATS_EN
  ,
  output logic [31:0]        pkt_count_o,
  output logic [31:0]        cfg_count_o,
  output logic               err_bad_rate_o
`endif
);

  localparam rate_entry_t DefaultEntry = '{
    len: LenW'(DEFAULT_VECTOR_LEN),
    vec: MaxLen'(DEFAULT_PUNCTURE_VECTOR)
  };

  state_e               state_q, state_d;
  logic [RW-1:0]        sel_q, sel_d;
  logic [RW-1:0]        cur_rate_q, cur_rate_d;
  logic                 cur_valid_q, cur_valid_d;
  logic                 run, cfg_v, bad_rate, need_cfg;
  logic [RW-1:0]        rate_idx;
  rate_entry_t          entry;
  logic [NUM_RATES-1:0] dirty;

  puncture_rate_table #(
    .NUM_RATES     (NUM_RATES),
    .RW            (RW),
    .DEFAULT_ENTRY (DefaultEntry)
  ) u_table (
    .clk     (clk),
    .reset   (reset),
    .we_i    (tbl_we_i),
    .waddr_i (tbl_addr_i),
    .wdata_i ('{len: tbl_len_i, vec: tbl_vec_i}),
    .raddr_i (sel_q),
    .apply_i (cfg_v),
    .rdata_o (entry),
    .dirty_o (dirty)
  );

  // Clear behaves like reset on the outputs so nothing is accepted while it is asserted.
  assign run      = !(reset || clear_i);
  assign bad_rate = rate_tdata_i >= SW'(NUM_RATES);
  assign rate_idx = bad_rate ? '0 : rate_tdata_i[RW-1:0];
  assign need_cfg = !cur_valid_q || (rate_idx != cur_rate_q) || dirty[rate_idx] ||
                    (tbl_we_i && tbl_addr_i == rate_idx);

  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    cur_rate_d    = cur_rate_q;
    cur_valid_d   = cur_valid_q;
    rate_tready_o = 1'b0;
    i_tready_o    = 1'b0;
    o_tvalid_o    = 1'b0;
    cfg_v         = 1'b0;
    if (run) begin
      unique case (state_q)
        StIdle: begin
          rate_tready_o = 1'b1;
          if (rate_tvalid_i) begin
            sel_d   = rate_idx;
            state_d = need_cfg ? StCfg : StPass;
          end
        end
        StCfg: begin
          cfg_v       = 1'b1;
          cur_rate_d  = sel_q;
          cur_valid_d = 1'b1;
          state_d     = StPass;
        end
        StPass: begin
          i_tready_o = o_tready_i;
          o_tvalid_o = i_tvalid_i;
          if (i_tvalid_i && o_tready_i && i_tlast_i) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      state_q     <= StIdle;
      sel_q       <= '0;
      cur_rate_q  <= '0;
      cur_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      cur_rate_q  <= cur_rate_d;
      cur_valid_q <= cur_valid_d;
    end
  end

  assign o_tdata_o                = i_tdata_i;
  assign o_tlast_o                = i_tlast_i;
  assign vector_len_tvalid_o      = cfg_v;
  assign puncture_vector_tvalid_o = cfg_v;
  assign vector_len_tdata_o       = cfg_v ? entry.len : '0;
  assign puncture_vector_tdata_o  = cfg_v ? entry.vec : '0;

`ifdef PUNCTURE_SCHED_STATS_EN
  logic [31:0] pkt_count_q, cfg_count_q;
  logic        err_q;

  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      pkt_count_q <= '0;
      cfg_count_q <= '0;
      err_q       <= 1'b0;
    end else begin
      if (o_tvalid_o && o_tready_i && i_tlast_i) pkt_count_q <= pkt_count_q + 32'd1;
      if (cfg_v)                                 cfg_count_q <= cfg_count_q + 32'd1;
      if (rate_tready_o && rate_tvalid_i && bad_rate) err_q <= 1'b1;
    end
  end

  assign pkt_count_o    = pkt_count_q;
  assign cfg_count_o    = cfg_count_q;
  assign err_bad_rate_o = err_q;
`endif

endmodule
